// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset/lock sequencer with lock qualification, retry/fail and lock-loss re-sequencing.
module pll_rst_seq #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 65536,
    parameter int LOCK_STABLE      = 1024,
    parameter int MAX_RETRY        = 3
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       pll_ok,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] lost_cnt
);
    localparam int M01 = RST_PULSE_CYCLES > LOCK_TIMEOUT ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int MAXC = M01 > LOCK_STABLE ? M01 : LOCK_STABLE;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] RP_END = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LT_END = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] LS_END = CW'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {HOLD, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    sync;
    logic          lock_s;

    assign lock_s = sync[1];

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HOLD;
            cnt       <= '0;
            sync      <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ok    <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
            lost_cnt  <= '0;
        end else begin
            sync <= {sync[0], pll_lock};
            if (restart) begin
                state     <= HOLD;
                cnt       <= '0;
                retry_cnt <= '0;
                fail      <= 1'b0;
                pll_reset <= 1'b1;
                sys_rst_n <= 1'b0;
                pll_ok    <= 1'b0;
            end else begin
                case (state)
                    HOLD: begin
                        if (cnt == RP_END) begin
                            state     <= WAIT_LOCK;
                            cnt       <= '0;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == LT_END) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            pll_reset <= 1'b1;
                            cnt       <= '0;
                            if (retry_cnt + 8'd1 == 8'(MAX_RETRY)) begin
                                state <= FAIL;
                                fail  <= 1'b1;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STABLE: begin
                        // A bounce only restarts the lock timeout; it is not a failed attempt.
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == LS_END) begin
                            state     <= RUN;
                            retry_cnt <= '0;
                            sys_rst_n <= 1'b1;
                            pll_ok    <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (!lock_s) begin
                            state     <= HOLD;
                            cnt       <= '0;
                            pll_reset <= 1'b1;
                            sys_rst_n <= 1'b0;
                            pll_ok    <= 1'b0;
                            lost_cnt  <= (lost_cnt == 8'd255) ? lost_cnt : lost_cnt + 8'd1;
                        end
                    end
                    default: begin
                        pll_reset <= 1'b1;
                        fail      <= 1'b1;
                        sys_rst_n <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

PLL reset/lock sequencer that runs on the free-running board clock (27 MHz) ahead of the PLL that generates the DDR3 PHY/controller clock. It drives the PLL `reset` input, waits for and qualifies `lock`, and releases an active-low reset to the downstream clock domain only after lock has been stable. On lock timeout it retries, and after a bounded number of failed retries it parks in a FAIL state. On lock loss during run it re-sequences the PLL.

## Interface
- `RST_PULSE_CYCLES`, 16: cycles `pll_reset` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before an attempt is declared failed (≥2).
- `LOCK_STABLE`, 1024: consecutive synchronized-lock cycles required before release (≥2).
- `MAX_RETRY`, 3: failed attempts tolerated before FAIL (1..255).
- `clkin`  in  1: free-running reference clock, same net that feeds the PLL.
- `rst_n`  in  1: asynchronous active-low reset. Asserts immediately; release is synchronous to `clkin`.
- `pll_lock`  in  1: PLL `lock`. Asynchronous to `clkin`; the block synchronizes it with 2 flops.
- `restart`  in  1: single-cycle request to re-run the sequence from HOLD.
- `pll_reset`  out  1: drives the PLL `reset` input, active-high.
- `sys_rst_n`  out  1: active-low reset for the downstream logic. Downstream synchronizes it into its own domain.
- `pll_ok`  out  1: high in RUN.
- `fail`  out  1: high in FAIL.
- `retry_cnt`  out  8: failed attempts since the last success or restart.
- `lost_cnt`  out  8: lock-loss events seen in RUN. Saturates at 255.

## Operation
- States: HOLD, WAIT_LOCK, STABLE, RUN, FAIL. `lock_s` is the 2-flop synchronized `pll_lock`.
- All outputs are registered and change on the same edge as the state register.
- Reset values: state HOLD, cnt 0, `pll_reset`=1, `sys_rst_n`=0, `pll_ok`=0, `fail`=0, `retry_cnt`=0, `lost_cnt`=0, sync flops 0.
- HOLD:
  - `pll_reset`=1. cnt increments each cycle.
  - When cnt==RST_PULSE_CYCLES-1 → WAIT_LOCK, cnt←0.
- WAIT_LOCK:
  - `pll_reset`=0.
  - If `lock_s` → STABLE, cnt←0.
  - Else if cnt==LOCK_TIMEOUT-1: `retry_cnt`++. If the new value equals MAX_RETRY → FAIL; otherwise → HOLD, cnt←0.
  - Else cnt++.
- STABLE:
  - If `!lock_s` → WAIT_LOCK, cnt←0. The timeout restarts and `retry_cnt` is unchanged.
  - Else if cnt==LOCK_STABLE-1 → RUN, `retry_cnt`←0.
  - Else cnt++.
- RUN:
  - `sys_rst_n`=1, `pll_ok`=1.
  - If `!lock_s` → HOLD, cnt←0, `lost_cnt`++ (saturating). On that same edge `sys_rst_n`=0 and `pll_ok`=0.
- FAIL: `pll_reset`=1, `fail`=1, `sys_rst_n`=0. Exits only on `restart` or `rst_n`.
- `restart` has the highest priority in every state:
  - next state HOLD, cnt←0, `retry_cnt`←0, `fail`←0.
  - `lost_cnt` is kept.
  - `restart` held for several cycles keeps the block in HOLD with cnt at 0.
- cnt width is clog2 of max(RST_PULSE_CYCLES, LOCK_TIMEOUT, LOCK_STABLE). cnt never wraps, because every state exits at its terminal count.

## Timing
- `pll_reset` is high throughout `rst_n` low plus exactly RST_PULSE_CYCLES edges after release. The same pulse width applies to every retry and restart.
- Lock latency: if `pll_lock` rises before edge k and stays high, STABLE is entered at edge k+2 and `sys_rst_n`/`pll_ok` go high at edge k+2+LOCK_STABLE.
- Lock loss: if `pll_lock` falls before edge m while in RUN, `sys_rst_n`=0 and `pll_reset`=1 from edge m+2.
- A lock glitch that lasts one `clkin` cycle and is captured by the synchronizer is treated as a real loss.
- Asserting `rst_n` mid-sequence forces the reset values asynchronously, including `lost_cnt`←0.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.

- Nominal bring-up: release `rst_n`; `pll_reset` is high for exactly 4 edges. Raise `pll_lock` 5 cycles later → `sys_rst_n`=1 and `pll_ok`=1 exactly 10 edges after the lock rise; `retry_cnt`=0.
- Lock bounce in STABLE: lock high for 5 cycles, low for 2, then high → the block returns to WAIT_LOCK with no `pll_reset` pulse. Release happens 10 edges after the final rise; `retry_cnt`=0.
- Timeout and FAIL: hold `pll_lock` low.
  - After 20 cycles in WAIT_LOCK: `retry_cnt`=1 and a second 4-cycle `pll_reset` pulse.
  - After the second timeout: `fail`=1, `retry_cnt`=2, `pll_reset` stays high.
- Restart from FAIL: pulse `restart` for 1 cycle → `fail`=0 and `retry_cnt`=0 next edge, then a 4-cycle `pll_reset` pulse. Raising lock then gives release after 10 edges.
- Lock loss in RUN: drop `pll_lock` → `sys_rst_n`=0 two edges later, `lost_cnt`=1, and the full sequence re-runs. Repeat 256 times → `lost_cnt` holds at 255.
- Async reset mid-STABLE: assert `rst_n` → outputs take their reset values without waiting for a clock edge. After release the sequence restarts from HOLD.
